// File: rtl/i2c_boot_eeprom_target.sv
// I2C target emulating the boot EEPROM: 7-bit address match, one-byte word-pointer
// write, sequential reads from a synchronous ROM port with pointer auto-increment.
module i2c_boot_eeprom_target #(
  parameter logic [6:0]  DEV_ADDR = 7'b1010_000,
  parameter int unsigned PTR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             mem_rd_en,
  output logic [PTR_W-1:0] mem_addr,
  input  logic [7:0]       mem_rdata,
  output logic             busy,
  output logic [PTR_W-1:0] ptr
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               rw_q, rw_d;
  logic               first_wr_q, first_wr_d;
  logic               busy_q, busy_d;
  logic               sda_oe_q, sda_oe_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic [PTR_W-1:0]   mem_addr_q, mem_addr_d;
  logic               rd_pend_q, rd_pend_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic scl_rise, scl_fall, bus_start, bus_stop;

  assign scl_rise  = scl_s2_q & ~scl_d_q;
  assign scl_fall  = ~scl_s2_q & scl_d_q;
  assign bus_start = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
  assign bus_stop  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    first_wr_d  = first_wr_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    rd_pend_d   = mem_rd_en_q;
    ptr_d       = ptr_q;

    // ROM data arrives one clk after the strobe; always inside an ACK phase
    if (rd_pend_q) shreg_d = mem_rdata;

    if (bus_stop) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (bus_start) begin
      state_d  = S_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_IGNORE: ;
        S_ADDR: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_s2_q};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shreg_q[7:1] == DEV_ADDR) begin
              state_d    = S_ADDR_ACK;
              sda_oe_d   = 1'b1;
              busy_d     = 1'b1;
              rw_d       = shreg_q[0];
              first_wr_d = ~shreg_q[0];
              if (shreg_q[0]) begin
                mem_rd_en_d = 1'b1;
                mem_addr_d  = ptr_q;
              end
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d  = S_RD_BYTE;
              sda_oe_d = ~shreg_q[7];
            end else begin
              state_d  = S_WR_BYTE;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_s2_q};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d  = S_WR_ACK;
            sda_oe_d = 1'b1;
            if (first_wr_q) begin
              ptr_d      = PTR_W'(shreg_q);
              first_wr_d = 1'b0;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            state_d  = S_WR_BYTE;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
          end
        end
        S_RD_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = S_RD_ACK;
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + PTR_W'(1);
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s2_q) begin
              state_d = S_IGNORE;
            end else begin
              mem_rd_en_d = 1'b1;
              mem_addr_d  = ptr_q;
            end
          end else if (scl_fall) begin
            state_d  = S_RD_BYTE;
            cnt_d    = '0;
            sda_oe_d = ~shreg_q[7];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_d_q     <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_d_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      rw_q        <= 1'b0;
      first_wr_q  <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rd_pend_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      scl_s1_q    <= scl_i;
      scl_s2_q    <= scl_s1_q;
      scl_d_q     <= scl_s2_q;
      sda_s1_q    <= sda_i;
      sda_s2_q    <= sda_s1_q;
      sda_d_q     <= sda_s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      first_wr_q  <= first_wr_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rd_pend_q   <= rd_pend_d;
      ptr_q       <= ptr_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;
  assign ptr       = ptr_q;

endmodule

// File: doc/i2c_boot_eeprom_target.md
Name: i2c_boot_eeprom_target

Overview:
- I2C target (responder) that emulates the boot EEPROM on the other end of the boot-loader I2C controller.
- Oversamples SCL/SDA on one system clock, decodes START/STOP, and matches the 7-bit device address.
- Accepts a one-byte word-pointer write, then serves sequential reads from a synchronous ROM port with pointer auto-increment.
- Used as the on-chip/simulation stand-in for the external EEPROM so the boot path can be exercised end to end.

Parameters:
- DEV_ADDR, 7'b1010_000, 7-bit I2C target address.
- PTR_W, 8, word-pointer / ROM address width (pointer byte zero-extended or truncated to PTR_W).

Ports:
- clk  input  1  system clock, at least 8x SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- scl_i  input  1  raw SCL from the bus (target never drives SCL; no clock stretching).
- sda_i  input  1  raw SDA from the bus.
- sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
- mem_rd_en  output  1  one-cycle ROM read strobe.
- mem_addr  output  PTR_W  ROM read address, valid with mem_rd_en.
- mem_rdata  input  8  ROM data, valid exactly 1 clk after mem_rd_en.
- busy  output  1  1 from an addressed START through the following STOP/START.
- ptr  output  PTR_W  current word pointer (debug/verification visibility).

Behaviour:
- Reset: sda_oe=0, mem_rd_en=0, mem_addr=0, busy=0, ptr=0, state=IDLE. Synchronizer flops reset to 1 (idle bus).
- Input path: 2-flop synchronizer on SCL and SDA, plus one delay flop for edge detection; all decisions use synchronized values.
- Bus events (any state):
  - START = SDA fall while SCL high: bit counter cleared, state ADDR, sda_oe=0.
  - STOP = SDA rise while SCL high: state IDLE, sda_oe=0, busy=0.
  - START/STOP override any in-progress byte (mid-byte abort); a partial byte is discarded.
- Timing: SDA sampled on the synchronized SCL rising edge. sda_oe is updated on the clk after the synchronized SCL falling edge, i.e. 3 clk after raw SCL falls. sda_oe must not change while synchronized SCL is high, except on reset/STOP release.
- States:
  - IDLE: sda_oe=0, waits for START.
  - ADDR: shift 8 bits MSB first. On the 8th bit:
    - Bits[7:1]==DEV_ADDR: go to ADDR_ACK, busy=1.
    - Otherwise: go to IGNORE (NACK by releasing SDA).
  - ADDR_ACK: drive sda_oe=1 for one SCL period.
    - R/W=0: then WR_BYTE.
    - R/W=1: assert mem_rd_en with mem_addr=ptr during the ACK low phase, latch mem_rdata into the tx shift register, then RD_BYTE.
  - WR_BYTE: shift 8 bits, then WR_ACK (sda_oe=1 for one SCL period).
    - First data byte after an address-write loads ptr.
    - Further bytes are ACKed and discarded (ROM is read-only).
  - RD_BYTE: drive sda_oe = ~tx_bit for each of 8 bits, MSB first. After bit 0: sda_oe=0, ptr<=ptr+1 (wraps 2^PTR_W-1 -> 0), go to RD_ACK.
  - RD_ACK: sample controller ACK on SCL rise.
    - SDA=0 (ACK): issue mem_rd_en at the new ptr, load the shift register, return to RD_BYTE.
    - SDA=1 (NACK): go to IGNORE.
  - IGNORE: sda_oe=0, waits for START or STOP.
- Repeated START after the pointer write (write-ptr, Sr, read) is the normal boot sequence; ptr persists across START/STOP and is cleared only by rst.
- Reset mid-transfer: sda_oe releases immediately (asynchronous), bus considered idle.

Test Plan:
- START, 0xA0 (write), 0x05, Sr, 0xA1, read 3 bytes ACK/ACK/NACK, STOP with ROM[i]=i+0x10 -> target ACKs addr/ptr; reads 0x15,0x16,0x17; ptr=0x08; busy falls on STOP.
- START, 0xA2 (wrong address) -> no ACK (SDA high on 9th clock); bus ignored until STOP; busy stays 0; ptr unchanged.
- ptr=0xFF, read 2 bytes -> returns ROM[0xFF] then ROM[0x00]; ptr=0x01 (wrap).
- START, 0xA1, STOP issued after 4 data bits -> sda_oe=0 within 3 clk of STOP detect; state IDLE; next START, 0xA1 ACKed and reads resume at the unchanged ptr.
- rst asserted while sda_oe=1 during a read bit -> sda_oe=0 asynchronously, ptr=0; subsequent address phase ACKed normally.
- Write 0xA0, 0x10, 0x55, 0x66 -> all three bytes ACKed; ptr=0x10; no mem_rd_en pulses.
